timer_core_cmp: RTL and testbench

//  Parametrised free-running timer core: CNT_WIDTH-bit up-counter with a programmable

---
 rtl/timer_core_cmp_pkg.sv | 28 ++
 rtl/timer_core_cmp_if.sv | 12 +
 rtl/timer_core_cmp_prescaler.sv | 30 +++
 rtl/timer_core_cmp.sv | 138 +++++++++++++
 tb/tb_timer_core_cmp.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/timer_core_cmp_pkg.sv
// rtl/timer_core_cmp_pkg.sv - register offsets, TCR bit positions and TISR bit helpers
package timer_core_cmp_pkg;

   localparam int TCR_OFF     = 'h000;
   localparam int TDR_OFF     = 'h004;
   localparam int TIER_OFF    = 'h040;
   localparam int TISR_OFF    = 'h044;
   localparam int TCMP_OFF    = 'h100;
   localparam int TCMP_STRIDE = 'h10;

   localparam int TCR_EN_BIT     = 0;
   localparam int TCR_DIV_EN_BIT = 1;
   localparam int TCR_DIV_LSB    = 8;

   function automatic int tdr_off(input int w);
      return TDR_OFF + 4 * w;
   endfunction

   function automatic int tcmp_off(input int ch, input int w);
      return TCMP_OFF + TCMP_STRIDE * ch + 4 * w;
   endfunction

   // Overflow status sits directly above the compare channel bits.
   function automatic int ovf_bit(input int num_cmp);
      return num_cmp;
   endfunction

endpackage

// File: rtl/timer_core_cmp_if.sv
// rtl/timer_core_cmp_if.sv - decoded register bus between APB slave and timer core
interface timer_core_cmp_if #(
   parameter int ADDR_WIDTH = 12
);
   logic [ADDR_WIDTH-1:0] addr;
   logic                  wr_en;
   logic [31:0]           wdata;
   logic [31:0]           rdata;

   modport master (output addr, output wr_en, output wdata, input rdata);
   modport slave  (input addr, input wr_en, input wdata, output rdata);
endinterface

// File: rtl/timer_core_cmp_prescaler.sv
// rtl/timer_core_cmp_prescaler.sv - programmable prescaler producing the counter tick
module timer_prescaler
   import timer_core_cmp_pkg::*;
#(
   parameter int DIV_WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 timer_en,
   input  logic                 div_en,
   input  logic [DIV_WIDTH-1:0] div_val,
   input  logic                 halt,
   input  logic                 clr,
   output logic                 tick
);
   logic [DIV_WIDTH-1:0] presc;

   assign tick = timer_en & ~halt & (~div_en | (presc == div_val));

   // halt leaves presc untouched so the divide phase resumes where it stopped
   always_ff @(posedge clk) begin
      if (rst) begin
         presc <= '0;
      end else if (clr || !timer_en || tick) begin
         presc <= '0;
      end else if (div_en && !halt) begin
         presc <= presc + DIV_WIDTH'(1);
      end
   end
endmodule

// File: rtl/timer_core_cmp.sv
// rtl/timer_core_cmp.sv - free-running timer with prescaler, compare channels and overflow irq
module timer_core_cmp
   import timer_core_cmp_pkg::*;
#(
   parameter int CNT_WIDTH  = 64,
   parameter int NUM_CMP    = 2,
   parameter int DIV_WIDTH  = 8,
   parameter int ADDR_WIDTH = 12
) (
   input  logic                 clk,
   input  logic                 rst,
   timer_core_cmp_if.slave      bus,
   input  logic                 halt,
   output logic [CNT_WIDTH-1:0] cnt,
   output logic                 irq
);
   localparam int CNT_WORDS = CNT_WIDTH / 32;
   localparam int ST_W      = NUM_CMP + 1;

   logic                             timer_en, div_en;
   logic [DIV_WIDTH-1:0]             div_val;
   logic [ST_W-1:0]                  tier, tisr, tisr_set, tisr_clr;
   logic [NUM_CMP-1:0]               cmp_hit;
   logic [NUM_CMP-1:0][CNT_WIDTH-1:0] tcmp;
   logic [CNT_WIDTH-1:0]             cnt_inc;
   logic [ADDR_WIDTH-1:0]            a_al;
   logic [1:0]                       unused_addr;
   logic                             tcr_wr, tier_wr, tisr_wr, tdr_wr, tick, hw_step;
   logic [CNT_WORDS-1:0]             tdr_hit;
   logic [NUM_CMP-1:0][CNT_WORDS-1:0] tcmp_hit;

   assign a_al        = {bus.addr[ADDR_WIDTH-1:2], 2'b00};
   assign unused_addr = bus.addr[1:0];
   assign tcr_wr      = bus.wr_en && (a_al == ADDR_WIDTH'(TCR_OFF));
   assign tier_wr     = bus.wr_en && (a_al == ADDR_WIDTH'(TIER_OFF));
   assign tisr_wr     = bus.wr_en && (a_al == ADDR_WIDTH'(TISR_OFF));

   always_comb begin
      tdr_hit  = '0;
      tcmp_hit = '0;
      for (int w = 0; w < CNT_WORDS; w++) begin
         tdr_hit[w] = bus.wr_en && (a_al == ADDR_WIDTH'(tdr_off(w)));
         for (int ch = 0; ch < NUM_CMP; ch++) begin
            tcmp_hit[ch][w] = bus.wr_en && (a_al == ADDR_WIDTH'(tcmp_off(ch, w)));
         end
      end
   end

   assign tdr_wr = |tdr_hit;

   timer_prescaler #(.DIV_WIDTH(DIV_WIDTH)) u_presc (
      .clk      (clk),
      .rst      (rst),
      .timer_en (timer_en),
      .div_en   (div_en),
      .div_val  (div_val),
      .halt     (halt),
      .clr      (tcr_wr),
      .tick     (tick)
   );

   // A software load pre-empts the tick, so neither compare nor overflow can fire from it
   assign hw_step = tick & ~tdr_wr;
   assign cnt_inc = cnt + CNT_WIDTH'(1);

   always_ff @(posedge clk) begin
      if (rst) begin
         timer_en <= 1'b0;
         div_en   <= 1'b0;
         div_val  <= '0;
      end else if (tcr_wr) begin
         timer_en <= bus.wdata[TCR_EN_BIT];
         div_en   <= bus.wdata[TCR_DIV_EN_BIT];
         div_val  <= bus.wdata[TCR_DIV_LSB +: DIV_WIDTH];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (tdr_wr) begin
         for (int w = 0; w < CNT_WORDS; w++) begin
            if (tdr_hit[w]) cnt[32*w +: 32] <= bus.wdata;
         end
      end else if (tick) begin
         cnt <= cnt_inc;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tcmp <= '1;
      end else begin
         for (int ch = 0; ch < NUM_CMP; ch++) begin
            for (int w = 0; w < CNT_WORDS; w++) begin
               if (tcmp_hit[ch][w]) tcmp[ch][32*w +: 32] <= bus.wdata;
            end
         end
      end
   end

   // Matching against cnt+1 makes status appear together with the new count value
   for (genvar ch = 0; ch < NUM_CMP; ch++) begin : g_cmp
      assign cmp_hit[ch] = hw_step & (cnt_inc == tcmp[ch]);
   end

   assign tisr_set = {hw_step & (&cnt), cmp_hit};
   assign tisr_clr = tisr_wr ? bus.wdata[ST_W-1:0] : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         tier <= '0;
         tisr <= '0;
         irq  <= 1'b0;
      end else begin
         if (tier_wr) tier <= bus.wdata[ST_W-1:0];
         tisr <= (tisr & ~tisr_clr) | tisr_set;
         irq  <= |(tisr & tier);
      end
   end

   always_comb begin
      bus.rdata = '0;
      if (a_al == ADDR_WIDTH'(TCR_OFF)) begin
         bus.rdata[TCR_EN_BIT]                   = timer_en;
         bus.rdata[TCR_DIV_EN_BIT]               = div_en;
         bus.rdata[TCR_DIV_LSB +: DIV_WIDTH]     = div_val;
      end
      if (a_al == ADDR_WIDTH'(TIER_OFF)) bus.rdata = 32'(tier);
      if (a_al == ADDR_WIDTH'(TISR_OFF)) bus.rdata = 32'(tisr);
      for (int w = 0; w < CNT_WORDS; w++) begin
         if (a_al == ADDR_WIDTH'(tdr_off(w))) bus.rdata = cnt[32*w +: 32];
         for (int ch = 0; ch < NUM_CMP; ch++) begin
            if (a_al == ADDR_WIDTH'(tcmp_off(ch, w))) bus.rdata = tcmp[ch][32*w +: 32];
         end
      end
   end
endmodule

// File: tb/tb_timer_core_cmp.sv
// tb/tb_timer_core_cmp.sv - directed self-checking bench for timer_core_cmp
module tb_timer_core_cmp;
   localparam logic [11:0] A_TCR   = 12'h000;
   localparam logic [11:0] A_TDR0  = 12'h004;
   localparam logic [11:0] A_TDR1  = 12'h008;
   localparam logic [11:0] A_TIER  = 12'h040;
   localparam logic [11:0] A_TISR  = 12'h044;
   localparam logic [11:0] A_C0W0  = 12'h100;
   localparam logic [11:0] A_C0W1  = 12'h104;
   localparam logic [11:0] A_C1W0  = 12'h110;
   localparam logic [11:0] A_C1W1  = 12'h114;

   logic        clk = 1'b0;
   logic        rst;
   logic        halt;
   logic [63:0] cnt;
   logic        irq;
   logic [31:0] r;
   int          errors = 0;
   int          checks = 0;

   timer_core_cmp_if #(.ADDR_WIDTH(12)) bus ();

   timer_core_cmp #(
      .CNT_WIDTH(64), .NUM_CMP(2), .DIV_WIDTH(8), .ADDR_WIDTH(12)
   ) dut (
      .clk  (clk),
      .rst  (rst),
      .bus  (bus.slave),
      .halt (halt),
      .cnt  (cnt),
      .irq  (irq)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n = 1);
      repeat (n) @(negedge clk);
   endtask

   task automatic wr(input logic [11:0] a, input logic [31:0] d);
      bus.addr  = a;
      bus.wdata = d;
      bus.wr_en = 1'b1;
      @(negedge clk);
      bus.wr_en = 1'b0;
   endtask

   task automatic rd(input logic [11:0] a, output logic [31:0] d);
      bus.addr = a;
      #1;
      d = bus.rdata;
   endtask

   initial begin
      rst = 1'b1; halt = 1'b0;
      bus.addr = '0; bus.wr_en = 1'b0; bus.wdata = '0;
      step(2);
      chk("reset_cnt", cnt, 64'h0);
      chk("reset_irq", {63'h0, irq}, 64'h0);
      rd(A_C0W0, r); chk("reset_tcmp0_w0", {32'h0, r}, 64'hFFFF_FFFF);
      rd(A_C1W1, r); chk("reset_tcmp1_w1", {32'h0, r}, 64'hFFFF_FFFF);
      rd(A_TISR, r); chk("reset_tisr", {32'h0, r}, 64'h0);
      rst = 1'b0;

      // free run, no divider
      wr(A_TCR, 32'h1);
      chk("en_write_no_tick", cnt, 64'd0);
      step(); chk("run_cnt1", cnt, 64'd1);
      step(); chk("run_cnt2", cnt, 64'd2);
      step(); chk("run_cnt3", cnt, 64'd3);

      // divide by 4: TCR write edge still ticks with old config
      wr(A_TCR, 32'h0303);
      chk("div_write_edge", cnt, 64'd4);
      step(3); chk("div_hold", cnt, 64'd4);
      step();  chk("div_tick1", cnt, 64'd5);
      step(4); chk("div_tick2", cnt, 64'd6);

      // compare channel 0 at 10 with interrupt
      wr(A_TCR, 32'h0);
      wr(A_TDR0, 32'h0);
      wr(A_TDR1, 32'h0);
      wr(A_C0W0, 32'd10);
      wr(A_C0W1, 32'h0);
      wr(A_TIER, 32'h1);
      wr(A_TCR, 32'h1);
      chk("cmp_start", cnt, 64'd0);
      step(9);
      chk("cmp_cnt9", cnt, 64'd9);
      rd(A_TISR, r); chk("cmp_tisr_before", {32'h0, r}, 64'h0);
      step();
      chk("cmp_cnt10", cnt, 64'd10);
      rd(A_TISR, r); chk("cmp_tisr_set", {32'h0, r}, 64'h1);
      chk("cmp_irq_lag", {63'h0, irq}, 64'h0);
      step();
      chk("cmp_irq_set", {63'h0, irq}, 64'h1);
      wr(A_TISR, 32'h1);
      rd(A_TISR, r); chk("w1c_tisr", {32'h0, r}, 64'h0);
      chk("w1c_irq_lag", {63'h0, irq}, 64'h1);
      step();
      chk("w1c_irq_clr", {63'h0, irq}, 64'h0);

      // overflow with channel 1 compare at zero
      wr(A_C1W0, 32'h0);
      wr(A_C1W1, 32'h0);
      wr(A_TDR1, 32'hFFFF_FFFF);
      wr(A_TDR0, 32'hFFFF_FFFE);
      chk("ovf_load", cnt, 64'hFFFF_FFFF_FFFF_FFFE);
      step(); chk("ovf_max", cnt, 64'hFFFF_FFFF_FFFF_FFFF);
      rd(A_TISR, r); chk("ovf_tisr_before", {32'h0, r}, 64'h0);
      step(); chk("ovf_wrap", cnt, 64'h0);
      rd(A_TISR, r); chk("ovf_tisr", {32'h0, r}, 64'h6);
      step(); chk("ovf_irq_masked", {63'h0, irq}, 64'h0);
      wr(A_TISR, 32'h7);

      // TDR write on a tick edge wins, upper word preserved
      wr(A_TDR1, 32'h5);
      chk("tdr1_load", cnt, 64'h5_0000_0002);
      wr(A_TDR0, 32'h100);
      chk("tdr0_load_no_inc", cnt, 64'h5_0000_0100);
      rd(A_TDR1, r); chk("tdr1_read", {32'h0, r}, 64'h5);
      step(); chk("tdr_resume", cnt, 64'h5_0000_0101);

      // halt freezes counter and prescaler phase
      wr(A_TCR, 32'h0103);
      chk("div2_write_edge", cnt, 64'h5_0000_0102);
      step();
      halt = 1'b1;
      step(5);
      chk("halt_cnt", cnt, 64'h5_0000_0102);
      rd(A_TDR0, r); chk("halt_read", {32'h0, r}, 64'h102);
      halt = 1'b0;
      step();
      chk("halt_resume_tick", cnt, 64'h5_0000_0103);

      // hardware set beats same-cycle W1C
      wr(A_TCR, 32'h1);
      wr(A_C0W1, 32'h5);
      wr(A_C0W0, 32'h108);
      chk("setclr_pre", cnt, 64'h5_0000_0105);
      step(2);
      wr(A_TISR, 32'h1);
      chk("setclr_cnt", cnt, 64'h5_0000_0108);
      rd(A_TISR, r); chk("setclr_tisr", {32'h0, r}, 64'h1);
      step();
      chk("setclr_irq", {63'h0, irq}, 64'h1);

      // software load onto the compare value does not set status
      wr(A_TISR, 32'h1);
      wr(A_TDR0, 32'h108);
      rd(A_TISR, r); chk("load_no_cmp", {32'h0, r}, 64'h0);

      // mid-count reset
      rst = 1'b1;
      step();
      chk("rst2_cnt", cnt, 64'h0);
      chk("rst2_irq", {63'h0, irq}, 64'h0);
      rd(A_TCR, r);  chk("rst2_tcr", {32'h0, r}, 64'h0);
      rd(A_TIER, r); chk("rst2_tier", {32'h0, r}, 64'h0);
      rd(A_C0W0, r); chk("rst2_tcmp0", {32'h0, r}, 64'hFFFF_FFFF);
      rst = 1'b0;
      step();
      chk("rst2_idle", cnt, 64'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
